// File: rtl/rename_pkg.sv
// Shared types and default sizes for the register-rename stage.
package rename_pkg;

  localparam int unsigned NUM_PREGS_DEF  = 64;
  localparam int unsigned NUM_AREGS_DEF  = 32;
  localparam int unsigned FREE_PORTS_DEF = 2;
  localparam int unsigned PTAG_W_DEF     = $clog2(NUM_PREGS_DEF);
  localparam int unsigned AREG_W_DEF     = $clog2(NUM_AREGS_DEF);

  typedef logic [PTAG_W_DEF-1:0] ptag_t;
  typedef logic [AREG_W_DEF-1:0] areg_t;

  typedef struct packed {
    ptag_t prs1;
    ptag_t prs2;
    ptag_t prd;
    ptag_t prd_old;
    logic  rd_we;
  } renamed_t;

endpackage

// File: rtl/rename_map_if.sv
// Decode-side input, dispatch-side output and commit-side tag-return signals
// of the rename stage.
interface rename_map_if
  import rename_pkg::*;
#(
  parameter int unsigned NUM_PREGS  = NUM_PREGS_DEF,
  parameter int unsigned NUM_AREGS  = NUM_AREGS_DEF,
  parameter int unsigned FREE_PORTS = FREE_PORTS_DEF
);
  localparam int unsigned PTAG_W = $clog2(NUM_PREGS);
  localparam int unsigned AREG_W = $clog2(NUM_AREGS);

  logic                         in_valid;
  logic                         in_ready;
  logic [AREG_W-1:0]            in_rs1;
  logic [AREG_W-1:0]            in_rs2;
  logic [AREG_W-1:0]            in_rd;
  logic                         in_rd_we;
  logic                         out_valid;
  logic                         out_ready;
  logic [PTAG_W-1:0]            out_prs1;
  logic [PTAG_W-1:0]            out_prs2;
  logic [PTAG_W-1:0]            out_prd;
  logic [PTAG_W-1:0]            out_prd_old;
  logic                         out_rd_we;
  logic [FREE_PORTS-1:0]        free_valid;
  logic [FREE_PORTS*PTAG_W-1:0] free_tag;
  logic [PTAG_W:0]              free_count;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready, free_valid, free_tag,
    input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_rd_we, free_count
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready, free_valid, free_tag,
    output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_rd_we, free_count
  );

endinterface

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags: one pop port, FREE_PORTS push ports.
// Storage is NUM_PREGS deep so pointers wrap naturally on PTAG_W bits.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int unsigned NUM_PREGS  = NUM_PREGS_DEF,
  parameter int unsigned NUM_AREGS  = NUM_AREGS_DEF,
  parameter int unsigned FREE_PORTS = FREE_PORTS_DEF,
  localparam int unsigned PTAG_W    = $clog2(NUM_PREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pop,
  output logic [PTAG_W-1:0]            head_tag,
  input  logic [FREE_PORTS-1:0]        push_valid,
  input  logic [FREE_PORTS*PTAG_W-1:0] push_tag,
  output logic [PTAG_W:0]              count
);

  localparam logic [PTAG_W:0] RESET_COUNT = (PTAG_W+1)'(NUM_PREGS - NUM_AREGS);

  logic [PTAG_W-1:0] mem_q [NUM_PREGS];
  logic [PTAG_W-1:0] mem_d [NUM_PREGS];
  logic [PTAG_W-1:0] head_q, head_d;
  logic [PTAG_W-1:0] tail_q, tail_d;
  logic [PTAG_W:0]   count_q, count_d;

  assign head_tag = mem_q[head_q];
  assign count    = count_q;

  // Pop advances head; each returning port writes the next tail slot in port order.
  always_comb begin
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = head_q + PTAG_W'(pop);
    count_d = count_q - (PTAG_W+1)'(pop);
    for (int unsigned p = 0; p < FREE_PORTS; p++) begin
      if (push_valid[p]) begin
        mem_d[tail_d] = push_tag[p*PTAG_W +: PTAG_W];
        tail_d        = tail_d + PTAG_W'(1);
        count_d       = count_d + (PTAG_W+1)'(1);
      end
    end
  end

  // Reset loads mem[i]=i so slots NUM_AREGS.. already hold the initial free tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) mem_q[i] <= PTAG_W'(i);
      head_q  <= PTAG_W'(NUM_AREGS);
      tail_q  <= '0;
      count_q <= RESET_COUNT;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Protocol checks on returned tags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned p = 0; p < FREE_PORTS; p++) begin
        assert (!(push_valid[p] && push_tag[p*PTAG_W +: PTAG_W] == '0))
          else $error("rename_free_list: tag 0 returned on port %0d", p);
      end
      assert (count_d <= RESET_COUNT)
        else $error("rename_free_list: free list overflow");
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register-rename stage: RAT, allocation from the free list, and a registered
// valid/ready output slot towards dispatch.
module rename_map
  import rename_pkg::*;
#(
  parameter int unsigned NUM_PREGS  = NUM_PREGS_DEF,
  parameter int unsigned NUM_AREGS  = NUM_AREGS_DEF,
  parameter int unsigned FREE_PORTS = FREE_PORTS_DEF
) (
  input logic         clk,
  input logic         rst,
  rename_map_if.slave bus
);

  localparam int unsigned PTAG_W = $clog2(NUM_PREGS);

  typedef struct packed {
    logic [PTAG_W-1:0] prs1;
    logic [PTAG_W-1:0] prs2;
    logic [PTAG_W-1:0] prd;
    logic [PTAG_W-1:0] prd_old;
    logic              rd_we;
  } out_t;

  logic [PTAG_W-1:0] rat_q [NUM_AREGS];
  logic [PTAG_W-1:0] rat_d [NUM_AREGS];
  out_t              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              alloc, in_ready, accept, pop;
  logic [PTAG_W-1:0] head_tag;
  logic [PTAG_W:0]   fl_count;

  rename_free_list #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS),
    .FREE_PORTS(FREE_PORTS)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop       (pop),
    .head_tag  (head_tag),
    .push_valid(bus.free_valid),
    .push_tag  (bus.free_tag),
    .count     (fl_count)
  );

  // Handshake: x0 never allocates; allocation needs a tag present at cycle start.
  always_comb begin
    alloc    = bus.in_rd_we && (bus.in_rd != '0);
    in_ready = (!out_valid_q || bus.out_ready) && (!alloc || fl_count != '0);
    accept   = bus.in_valid && in_ready;
    pop      = accept && alloc;
  end

  // Sources read the RAT before this cycle's update, so rs==rd sees the old tag.
  always_comb begin
    rat_d       = rat_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d.prs1  = rat_q[bus.in_rs1];
      out_d.prs2  = rat_q[bus.in_rs2];
      out_valid_d = 1'b1;
      if (alloc) begin
        out_d.prd        = head_tag;
        out_d.prd_old    = rat_q[bus.in_rd];
        out_d.rd_we      = 1'b1;
        rat_d[bus.in_rd] = head_tag;
      end else begin
        out_d.prd     = '0;
        out_d.prd_old = '0;
        out_d.rd_we   = 1'b0;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // RAT, output slot and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) rat_q[i] <= PTAG_W'(i);
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rat_q       <= rat_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_prs1    = out_q.prs1;
  assign bus.out_prs2    = out_q.prs2;
  assign bus.out_prd     = out_q.prd;
  assign bus.out_prd_old = out_q.prd_old;
  assign bus.out_rd_we   = out_q.rd_we;
  assign bus.free_count  = fl_count;

endmodule

// File: tb/tb_rename_map.sv
// Scoreboard bench for rename_map: a queue/array reference model predicts each
// renamed instruction at acceptance; a monitor checks it when dispatch sees it.
module tb_rename_map;
  import rename_pkg::*;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int FP = 2;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_map_if #(.NUM_PREGS(NP), .NUM_AREGS(NA), .FREE_PORTS(FP)) bus ();

  rename_map #(.NUM_PREGS(NP), .NUM_AREGS(NA), .FREE_PORTS(FP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int       n_vec = 0;
  int       n_err = 0;
  renamed_t exp_q[$];
  int       prd_hist[$];
  renamed_t last_out;
  int       m_rat[NA];
  int       m_fl[$];
  int       retire_q[$];
  bit       m_ov;
  int       rdy_mode = 0;
  bit       rand_free = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NA; i++) m_rat[i] = i;
    m_fl.delete();
    for (int t = NA; t < NP; t++) m_fl.push_back(t);
    retire_q.delete();
    m_ov = 1'b0;
  endfunction

  // Reference model: predicts handshake, count and renamed result each cycle.
  initial begin
    bit       alloc, exp_rdy;
    renamed_t r;
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        m_reset();
        exp_q.delete();
      end else begin
        chk("free_count", int'(bus.free_count), m_fl.size());
        chk("out_valid", int'(bus.out_valid), int'(m_ov));
        alloc   = bus.in_rd_we && (bus.in_rd != 0);
        exp_rdy = (!m_ov || bus.out_ready) && (!alloc || m_fl.size() != 0);
        chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
        if (bus.in_valid && exp_rdy) begin
          r.prs1 = ptag_t'(m_rat[int'(bus.in_rs1)]);
          r.prs2 = ptag_t'(m_rat[int'(bus.in_rs2)]);
          if (alloc) begin
            r.prd     = ptag_t'(m_fl.pop_front());
            r.prd_old = ptag_t'(m_rat[int'(bus.in_rd)]);
            r.rd_we   = 1'b1;
            m_rat[int'(bus.in_rd)] = int'(r.prd);
            retire_q.push_back(int'(r.prd_old));
          end else begin
            r.prd     = '0;
            r.prd_old = '0;
            r.rd_we   = 1'b0;
          end
          exp_q.push_back(r);
          m_ov = 1'b1;
        end else if (bus.out_ready) begin
          m_ov = 1'b0;
        end
        for (int p = 0; p < FP; p++)
          if (bus.free_valid[p]) m_fl.push_back(int'(bus.free_tag[p*TW +: TW]));
      end
    end
  end

  // Monitor: compare the presented output with the oldest prediction.
  initial begin
    renamed_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", int'(bus.out_valid), 0);
        end else begin
          e = exp_q[0];
          chk("out_prs1", int'(bus.out_prs1), int'(e.prs1));
          chk("out_prs2", int'(bus.out_prs2), int'(e.prs2));
          chk("out_prd", int'(bus.out_prd), int'(e.prd));
          chk("out_prd_old", int'(bus.out_prd_old), int'(e.prd_old));
          chk("out_rd_we", int'(bus.out_rd_we), int'(e.rd_we));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            last_out = '{bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_prd_old, bus.out_rd_we};
            prd_hist.push_back(int'(bus.out_prd));
          end
        end
      end
    end
  end

  // Dispatch back-pressure.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Random commit: returns replaced tags in the order they were retired.
  initial forever begin
    @(posedge clk); #1;
    if (rand_free) begin
      for (int p = 0; p < FP; p++) begin
        if (retire_q.size() != 0 && $urandom_range(0, 2) == 0) begin
          bus.free_valid[p]          = 1'b1;
          bus.free_tag[p*TW +: TW]   = ptag_t'(retire_q.pop_front());
        end else begin
          bus.free_valid[p] = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.free_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_free_count", int'(bus.free_count), NP - NA);
    chk("rst_out_prd", int'(bus.out_prd), 0);
    chk("rst_out_prd_old", int'(bus.out_prd_old), 0);
    chk("rst_out_prs1", int'(bus.out_prs1), 0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input bit we);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_rs1   = areg_t'(rs1);
    bus.in_rs2   = areg_t'(rs2);
    bus.in_rd    = areg_t'(rd);
    bus.in_rd_we = we;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    bus.in_valid   = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_rd_we   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.free_valid = '0;
    bus.free_tag   = '0;

    // Single rename from reset.
    do_reset();
    issue(0, 0, 2, 1'b1);
    drain();
    chk("t1_prd", int'(last_out.prd), 32);
    chk("t1_prd_old", int'(last_out.prd_old), 2);
    chk("t1_prs1", int'(last_out.prs1), 0);
    chk("t1_free_count", int'(bus.free_count), 31);

    // Dependent back-to-back renames.
    do_reset();
    issue(1, 0, 2, 1'b1);
    issue(2, 0, 3, 1'b1);
    drain();
    chk("t2_prs1", int'(last_out.prs1), 32);
    chk("t2_prd", int'(last_out.prd), 33);
    chk("t2_prd_old", int'(last_out.prd_old), 3);

    // x0 destination never allocates.
    issue(0, 0, 0, 1'b1);
    drain();
    chk("t3_rd_we", int'(last_out.rd_we), 0);
    chk("t3_prd", int'(last_out.prd), 0);
    chk("t3_free_count", int'(bus.free_count), 30);

    // Exhaust the list, then a same-cycle return must not bypass.
    do_reset();
    repeat (32) issue(1, 0, 1, 1'b1);
    drain();
    chk("t4_empty", int'(bus.free_count), 0);
    bus.in_valid = 1'b1; bus.in_rd = areg_t'(1); bus.in_rd_we = 1'b1;
    @(negedge clk);
    chk("t4_stall_empty", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.free_valid = 2'b01;
    bus.free_tag   = {ptag_t'(0), ptag_t'(40)};
    @(negedge clk);
    chk("t4_stall_return", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.free_valid = '0;
    @(negedge clk);
    chk("t4_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    chk("t4_prd", int'(last_out.prd), 40);
    chk("t4_prd_old", int'(last_out.prd_old), 63);

    // Two returns while allocating at count 3; FIFO order afterwards.
    do_reset();
    issue(0, 0, 5, 1'b1);
    issue(0, 0, 9, 1'b1);
    repeat (27) issue(0, 0, 1, 1'b1);
    drain();
    chk("t5_count3", int'(bus.free_count), 3);
    bus.in_valid = 1'b1; bus.in_rd = areg_t'(1); bus.in_rd_we = 1'b1;
    bus.free_valid = 2'b11;
    bus.free_tag   = {ptag_t'(9), ptag_t'(5)};
    @(negedge clk);
    chk("t5_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.free_valid = '0;
    @(negedge clk);
    chk("t5_count4", int'(bus.free_count), 4);
    @(posedge clk); #1;
    prd_hist.delete();
    repeat (4) issue(0, 0, 1, 1'b1);
    drain();
    chk("t5_hist_len", prd_hist.size(), 4);
    if (prd_hist.size() == 4) begin
      chk("t5_first", prd_hist[2], 5);
      chk("t5_second", prd_hist[3], 9);
    end

    // Output hold under back-pressure, then reset mid-stream.
    do_reset();
    rdy_mode = 2; bus.out_ready = 1'b0;
    issue(3, 4, 6, 1'b1);
    bus.in_valid = 1'b1; bus.in_rs1 = areg_t'(6); bus.in_rd = areg_t'(7); bus.in_rd_we = 1'b1;
    c = int'(bus.free_count);
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_ready", int'(bus.in_ready), 0);
      chk("t6_hold_count", int'(bus.free_count), c);
      chk("t6_hold_prd", int'(bus.out_prd), 32);
    end
    @(posedge clk); #1;
    do_reset();
    rdy_mode = 0; bus.out_ready = 1'b1;
    issue(6, 13, 0, 1'b0);
    drain();
    chk("t6_rat_prs1", int'(last_out.prs1), 6);
    chk("t6_rat_prs2", int'(last_out.prs2), 13);

    // Randomized traffic with back-pressure and commit returns.
    do_reset();
    rand_free = 1'b1;
    rdy_mode  = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        issue(int'($urandom_range(0, NA-1)), int'($urandom_range(0, NA-1)),
              int'($urandom_range(0, NA-1)), 1'($urandom_range(0, 3) != 0));
      end
    end
    rand_free      = 1'b0;
    bus.free_valid = '0;
    rdy_mode       = 0;
    bus.out_ready  = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
